// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 hex keypad scanner and its display twin.
package keypad_pkg;

  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_PRESSED  = 2'd2,
    ST_RELEASE  = 2'd3
  } kp_state_e;

  // One-cold strobe start pattern, identical to the display ground pattern.
  localparam logic [3:0] ROW_RESET = 4'b1110;

  localparam logic [3:0] KEYMAP [4][4] = '{
    '{4'h1, 4'h2, 4'h3, 4'hA},
    '{4'h4, 4'h5, 4'h6, 4'hB},
    '{4'h7, 4'h8, 4'h9, 4'hC},
    '{4'hE, 4'h0, 4'hF, 4'hD}
  };

  // Position of the lowest zero bit in an active-low 4-bit vector.
  function automatic logic [1:0] low_index(input logic [3:0] v);
    if (!v[0])      low_index = 2'd0;
    else if (!v[1]) low_index = 2'd1;
    else if (!v[2]) low_index = 2'd2;
    else            low_index = 2'd3;
  endfunction

endpackage

// File: rtl/scan_tick_gen.sv
// Free-running power-of-two divider emitting a one-cycle tick when all-ones.
module scan_tick_gen #(
  parameter int unsigned DIV_BITS = 15
) (
  input  logic clk,
  input  logic rst,
  output logic tick_c
);

  logic [DIV_BITS-1:0] cnt_q;
  logic [DIV_BITS-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q + DIV_BITS'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign tick_c = &cnt_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad row scanner with debounce, valid/ready key delivery and a
// four-digit history register for the 7-segment display.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_DIV_BITS  = 15,
  parameter int unsigned DEBOUNCE_SCANS = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic [3:0]  rows,
  input  logic [3:0]  cols,
  output logic [3:0]  key_code,
  output logic        key_valid,
  input  logic        key_ready,
  output logic        key_down,
  output logic        overrun,
  output logic [15:0] digits
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_SCANS + 1);

  logic            tick_c;
  logic [3:0]      cols_m_q, cols_s_q;
  kp_state_e       state_q, state_d;
  logic [3:0]      rows_q, rows_d;
  logic [1:0]      cand_q, cand_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc_c;
  logic [3:0]      key_code_q, key_code_d;
  logic            key_valid_q, key_valid_d;
  logic            key_down_q, key_down_d;
  logic            overrun_q, overrun_d;
  logic [15:0]     digits_q, digits_d;
  logic            single_c, accept_c, deb_done_c;
  logic [1:0]      col_c, row_c;
  logic [3:0]      code_c;

  scan_tick_gen #(.DIV_BITS(SCAN_DIV_BITS)) u_tick (
    .clk    (clk),
    .rst    (rst),
    .tick_c (tick_c)
  );

  // Ghosted samples (two or more columns low) decode as "no key".
  assign single_c   = $onehot(~cols_s_q);
  assign col_c      = low_index(cols_s_q);
  assign row_c      = low_index(rows_q);
  assign code_c     = KEYMAP[row_c][cand_q];
  assign cnt_inc_c  = cnt_q + CNT_W'(1);
  assign deb_done_c = (cnt_inc_c == CNT_W'(DEBOUNCE_SCANS));

  always_comb begin
    state_d     = state_q;
    rows_d      = rows_q;
    cand_d      = cand_q;
    cnt_d       = cnt_q;
    key_code_d  = key_code_q;
    key_valid_d = key_valid_q & ~key_ready;
    key_down_d  = key_down_q;
    overrun_d   = 1'b0;
    digits_d    = digits_q;
    accept_c    = 1'b0;

    if (tick_c) begin
      case (state_q)
        ST_SCAN: begin
          if (single_c) begin
            cand_d  = col_c;
            cnt_d   = CNT_W'(1);
            state_d = ST_DEBOUNCE;
          end else begin
            rows_d = {rows_q[2:0], rows_q[3]};
          end
        end
        ST_DEBOUNCE: begin
          if (single_c && (col_c == cand_q)) begin
            cnt_d = cnt_inc_c;
            if (deb_done_c) begin
              accept_c   = 1'b1;
              key_down_d = 1'b1;
              state_d    = ST_PRESSED;
            end
          end else begin
            state_d = ST_SCAN;
          end
        end
        ST_PRESSED: begin
          if (!single_c) begin
            cnt_d   = CNT_W'(1);
            state_d = ST_RELEASE;
          end
        end
        ST_RELEASE: begin
          if (!single_c) begin
            cnt_d = cnt_inc_c;
            if (deb_done_c) begin
              key_down_d = 1'b0;
              state_d    = ST_SCAN;
            end
          end else begin
            state_d = ST_PRESSED;
          end
        end
        default: state_d = ST_SCAN;
      endcase
    end

    // History always records the key; delivery only if the slot is free.
    if (accept_c) begin
      digits_d = {digits_q[11:0], code_c};
      if (!key_valid_q || key_ready) begin
        key_code_d  = code_c;
        key_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cols_m_q    <= 4'hF;
      cols_s_q    <= 4'hF;
      state_q     <= ST_SCAN;
      rows_q      <= ROW_RESET;
      cand_q      <= 2'd0;
      cnt_q       <= '0;
      key_code_q  <= 4'h0;
      key_valid_q <= 1'b0;
      key_down_q  <= 1'b0;
      overrun_q   <= 1'b0;
      digits_q    <= 16'h0000;
    end else begin
      cols_m_q    <= cols;
      cols_s_q    <= cols_m_q;
      state_q     <= state_d;
      rows_q      <= rows_d;
      cand_q      <= cand_d;
      cnt_q       <= cnt_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      key_down_q  <= key_down_d;
      overrun_q   <= overrun_d;
      digits_q    <= digits_d;
    end
  end

  assign rows      = rows_q;
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign key_down  = key_down_q;
  assign overrun   = overrun_q;
  assign digits    = digits_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a physical keypad model feeds the column lines and a
// scoreboard checks every delivered key, overrun pulse and the digit history.
module tb_keypad_scanner;

  localparam int TICK = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  rows;
  logic [3:0]  cols;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_ready;
  logic        key_down;
  logic        overrun;
  logic [15:0] digits;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [15:0] pressed_mask = 16'h0;
  int          ready_mode = 1;
  logic [3:0]  sb_q[$];
  int          exp_ovr = 0;
  logic [15:0] exp_digits = 16'h0;
  string       km = "123A456B789CE0FD";

  keypad_scanner #(.SCAN_DIV_BITS(2), .DEBOUNCE_SCANS(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .rows      (rows),
    .cols      (cols),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .key_down  (key_down),
    .overrun   (overrun),
    .digits    (digits)
  );

  always #5 clk = ~clk;

  // Switch matrix: a held key shorts its column low while its row is strobed.
  always_comb begin
    cols = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed_mask[r*4+c] && !rows[r]) cols[c] = 1'b0;
  end

  function automatic logic [3:0] code_of(input int r, input int c);
    byte ch;
    ch = km[r*4+c];
    if (ch >= "A") code_of = 4'(ch - 8'd55);
    else           code_of = 4'(ch - 8'd48);
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_ticks(input int n);
    repeat (n * TICK) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    exp_digits = 16'h0;
  endtask

  // A long hold is always accepted exactly once; short holds never are.
  task automatic hold_key(input int r, input int c, input bit deliver);
    logic [3:0] k;
    k = code_of(r, c);
    exp_digits = {exp_digits[11:0], k};
    if (deliver) sb_q.push_back(k);
    pressed_mask = 16'(1) << (r*4+c);
    wait_ticks(12);
    check("key_down_held", 16'(key_down), 16'h1);
    check("digits_after_press", digits, exp_digits);
  endtask

  task automatic release_keys();
    pressed_mask = 16'h0;
    wait_ticks(8);
    check("key_down_released", 16'(key_down), 16'h0);
  endtask

  // Ready driver: fixed levels or random with a guaranteed ready every few cycles.
  initial begin
    int zero_run;
    zero_run = 0;
    key_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      case (ready_mode)
        0: key_ready = 1'b0;
        1: key_ready = 1'b1;
        default: begin
          key_ready = (zero_run >= 6) ? 1'b1 : (($urandom % 4) != 0);
          zero_run  = key_ready ? 0 : zero_run + 1;
        end
      endcase
    end
  end

  // Monitor: compares each transfer and overrun pulse with the scoreboard.
  always @(negedge clk) begin
    if (!rst && key_valid && key_ready) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_key: got %0h expected none", key_code);
      end else begin
        check("delivered_key", 16'(key_code), 16'(sb_q.pop_front()));
      end
    end
    if (!rst && overrun) begin
      n_checks++;
      if (exp_ovr > 0) exp_ovr--;
      else begin
        n_errors++;
        $display("FAIL unexpected_overrun: got 1 expected 0");
      end
    end
  end

  initial begin
    logic [3:0] prev;
    logic [3:0] exp_rows;
    int k;
    rst = 1'b1;

    // Reset state and idle rotation every 4 clocks.
    do_reset();
    check("rst_rows", 16'(rows), 16'hE);
    check("rst_valid", 16'(key_valid), 16'h0);
    check("rst_down", 16'(key_down), 16'h0);
    check("rst_overrun", 16'(overrun), 16'h0);
    check("rst_digits", digits, 16'h0);
    exp_rows = 4'b1110;
    for (int i = 0; i < 4; i++) begin
      prev = rows;
      k = 0;
      do begin
        @(posedge clk);
        #1;
        k++;
      end while (rows == prev && k < 8);
      exp_rows = {exp_rows[2:0], exp_rows[3]};
      check("idle_interval", 16'(k), 16'd4);
      check("idle_rows", 16'(rows), 16'(exp_rows));
    end
    check("idle_valid", 16'(key_valid), 16'h0);

    // Clean press of '6' (row 1, col 2).
    hold_key(1, 2, 1'b1);
    check("press6_rows_frozen", 16'(rows), 16'hD);
    check("press6_digits", digits, 16'h0006);
    release_keys();
    prev = rows;
    wait_ticks(2);
    check("scan_resumed", 16'(rows != prev), 16'h1);

    // Bounce: key toggles every tick, never three stable samples.
    for (int i = 0; i < 10; i++) begin
      pressed_mask = (i % 2 == 0) ? 16'h0040 : 16'h0000;
      wait_ticks(1);
    end
    pressed_mask = 16'h0;
    wait_ticks(6);
    check("bounce_digits", digits, exp_digits);
    check("bounce_down", 16'(key_down), 16'h0);

    // Backpressure: second key is dropped with an overrun pulse.
    do_reset();
    ready_mode = 0;
    hold_key(0, 0, 1'b1);
    release_keys();
    exp_ovr++;
    hold_key(0, 1, 1'b0);
    release_keys();
    check("ovr_code", 16'(key_code), 16'h1);
    check("ovr_valid", 16'(key_valid), 16'h1);
    check("ovr_digits", digits, 16'h0012);
    check("ovr_seen", 16'(exp_ovr), 16'h0);
    ready_mode = 1;
    @(posedge clk);
    #1;
    check("ovr_valid_cleared", 16'(key_valid), 16'h0);

    // Ghost: two keys on row 0 give cols=1001, rejected while rows rotates.
    pressed_mask = 16'h0006;
    k = 0;
    for (int i = 0; i < 12; i++) begin
      prev = rows;
      wait_ticks(1);
      if (rows != prev) k++;
    end
    pressed_mask = 16'h0;
    check("ghost_rotations", 16'(k >= 10), 16'h1);
    check("ghost_digits", digits, exp_digits);
    check("ghost_down", 16'(key_down), 16'h0);
    wait_ticks(4);

    // Reset while PRESSED with a pending key, then re-detection of the held key.
    do_reset();
    ready_mode = 0;
    hold_key(1, 1, 1'b0);
    check("pend_valid", 16'(key_valid), 16'h1);
    check("pend_code", 16'(key_code), 16'h5);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_rows", 16'(rows), 16'hE);
    check("midrst_valid", 16'(key_valid), 16'h0);
    check("midrst_down", 16'(key_down), 16'h0);
    check("midrst_digits", digits, 16'h0);
    rst = 1'b0;
    exp_digits = 16'h0;
    ready_mode = 2;
    hold_key(1, 1, 1'b1);
    check("redetect_digits", digits, 16'h0005);
    release_keys();

    // Random presses: long holds are accepted, short blips are not.
    for (int i = 0; i < 24; i++) begin
      int r, c;
      r = $urandom_range(3, 0);
      c = $urandom_range(3, 0);
      if ($urandom_range(2, 0) != 0) begin
        hold_key(r, c, 1'b1);
        release_keys();
      end else begin
        pressed_mask = 16'(1) << (r*4+c);
        wait_ticks($urandom_range(2, 1));
        pressed_mask = 16'h0;
        wait_ticks(6);
        check("blip_digits", digits, exp_digits);
        check("blip_down", 16'(key_down), 16'h0);
      end
    end

    repeat (20) @(posedge clk);
    #1;
    check("scoreboard_empty", 16'(sb_q.size()), 16'h0);
    check("overrun_consumed", 16'(exp_ovr), 16'h0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Input-side counterpart of the multiplexed 7-segment display driver, for a 4x4 hex keypad.
- Strobes one keypad row low at a time (same rotating one-cold scheme as the display grounds) and reads the four column lines.
- Debounces presses and releases, and delivers each accepted key as a 4-bit hex code over a valid/ready handshake.
- Maintains a 16-bit shift register of the last four keys; it plugs straight into the display's 16-bit number input.

Parameters:
- SCAN_DIV_BITS, 15: scan tick every 2^SCAN_DIV_BITS clk cycles.
- DEBOUNCE_SCANS, 4: consecutive identical samples needed to accept a press or a release (minimum 2).

Ports:
- clk  input  1  system clock; all logic on posedge clk.
- rst  input  1  synchronous, active-high reset.
- rows  output  4  row drive, active-low, exactly one bit low.
- cols  input  4  column sense, active-low (pulled up externally), asynchronous.
- key_code  output  4  hex code of the held key.
- key_valid  output  1  key_code holds an undelivered key.
- key_ready  input  1  consumer accepts; transfer occurs when key_valid && key_ready.
- key_down  output  1  debounced "a key is currently pressed" level.
- overrun  output  1  one-cycle pulse when an accepted key is dropped.
- digits  output  16  last four accepted keys; newest key in [3:0].

Behaviour:
- Reset (synchronous, rst high at posedge clk):
  - rows=4'b1110, key_code=0, key_valid=0, key_down=0, overrun=0, digits=0.
  - state=SCAN; divider, debounce count and synchronizer all cleared.
- Column synchronizer: cols passes through two flops (cols_s); all decisions use cols_s.
- Scan tick:
  - Free-running SCAN_DIV_BITS-bit divider; tick is a one-cycle pulse when the divider is all-ones, after which it wraps to 0.
  - Nothing below advances except on tick.
- Row index r is derived from the low bit of rows (1110=r0, 1101=r1, 1011=r2, 0111=r3).
- Column index c is the single low bit of cols_s.
  - A sample with no bit low counts as "no key".
  - A sample with two or more bits low also counts as "no key"; ghost/multi-key presses are rejected.
- Keymap (r,c -> code):
  - r0: 1 2 3 A
  - r1: 4 5 6 B
  - r2: 7 8 9 C
  - r3: E 0 F D
- State machine (transitions on tick only):
  - SCAN:
    - valid single key in cols_s: latch candidate c, count=1, go to DEBOUNCE; rows frozen.
    - otherwise: rows rotates left, {rows[2:0],rows[3]}.
  - DEBOUNCE:
    - sample equals candidate: count++. When count reaches DEBOUNCE_SCANS, accept the key, set key_down=1, go to PRESSED.
    - sample differs: go to SCAN and resume rotation.
  - PRESSED:
    - sample is "no key": count=1, go to RELEASE.
    - anything else (including a different column): stay.
  - RELEASE:
    - "no key": count++. When count reaches DEBOUNCE_SCANS, set key_down=0, go to SCAN and resume rotation.
    - key seen again: go to PRESSED.
- Accept action (same clk edge as the transition into PRESSED):
  - digits <= {digits[11:0], code}; this happens unconditionally.
  - If key_valid==0, or key_ready==1 in that cycle: key_code<=code, key_valid<=1.
  - Otherwise: keep the old key_code, drop the new key, pulse overrun.
- Handshake:
  - key_valid stays high, with key_code stable, until a cycle with key_ready=1. It clears on the next edge unless an accept reloads it in that same edge.
  - Simultaneous transfer and accept: the new key is loaded and key_valid stays 1, with no overrun.
- Key repeat: holding a key produces exactly one accept, and there is no auto-repeat.
- Reset mid-operation (any state): returns to the reset values above on the next edge. A pending key_valid is discarded.
- Latency: a key stable from a tick onward is accepted DEBOUNCE_SCANS-1 ticks after the first sampling tick, plus 2 clk for synchronization.

Decomposition:
- Shared package keypad_pkg holds:
  - the state enum (SCAN, DEBOUNCE, PRESSED, RELEASE);
  - the 4x4 keymap constant array, indexed [row][col];
  - the ROW_RESET constant 4'b1110, shared with the display driver's ground pattern.
- One natural sub-module: scan_tick_gen, the parameterised divider producing the one-cycle tick. It is reusable by the display driver in place of its clock-bit tap.

Test Plan (SCAN_DIV_BITS=2, DEBOUNCE_SCANS=3, key_ready=1 unless stated):
- Reset and idle scanning:
  - Stimulus: rst for 2 cycles, cols=4'hF.
  - Required: rows cycles 1110,1101,1011,0111,1110 every 4 clk; key_valid=0; digits=0.
- Clean press of '6':
  - Stimulus: cols=1011 while rows=1101.
  - Required: rows freezes at 1101; after 3 matching ticks, key_code=6 and key_valid pulses for 1 cycle; key_down=1; digits=0x0006.
  - Required on release: key_down=0 after 3 no-key ticks, then scanning resumes.
- Bounce rejection:
  - Stimulus: cols toggles 1011/1111 on alternate ticks for 10 ticks.
  - Required: no key_valid, digits unchanged.
- Backpressure / overrun:
  - Stimulus: key_ready=0; press '1', release, press '2'.
  - Required: key_code stays 1 with key_valid=1; overrun pulses once; digits=0x0012.
  - Stimulus continued: raise key_ready.
  - Required: key_valid clears next cycle.
- Multi-key ghost:
  - Stimulus: cols=1001 on row r0.
  - Required: treated as no key; rows keeps rotating; no accept.
- Reset mid-press:
  - Stimulus: rst asserted while in PRESSED with key_valid=1.
  - Required: next edge gives rows=1110, key_valid=0, key_down=0, digits=0.
  - Required after rst drops with the key still held: re-detected as one new press.
